// File: rtl/dcim_pkg.sv
// dcim_pkg: shared constants and helpers for the DCIM macro local MAC slice.
//   LANES  - lanes per bit-cell row
//   WBITS  - stored weight width per lane
//   OUT_W  - saturated local MAC result width
//   ROW_W  - signed width of one row's gated sum
//   SUM_W  - signed width of the two-row raw sum
//   U_MAX / S_MAX / S_MIN - saturation limits for unsigned / signed modes
package dcim_pkg;

  localparam int LANES = 8;
  localparam int WBITS = 12;
  localparam int OUT_W = 15;
  localparam int ROW_W = 16;
  localparam int SUM_W = 17;

  localparam logic signed [SUM_W-1:0] U_MAX = 17'sd32767;
  localparam logic signed [SUM_W-1:0] S_MAX = 17'sd16383;
  localparam logic signed [SUM_W-1:0] S_MIN = -17'sd16384;

  // Clamp the raw 17-bit sum into the 15-bit result range. In unsigned
  // mode the sum is never negative, so only the upper bound applies.
  function automatic logic [OUT_W-1:0] sat_result(
    input logic signed [SUM_W-1:0] s,
    input logic                    sus
  );
    logic signed [SUM_W-1:0] c;
    if (!sus) begin
      c = (s > U_MAX) ? U_MAX : s;
    end else if (s > S_MAX) begin
      c = S_MAX;
    end else if (s < S_MIN) begin
      c = S_MIN;
    end else begin
      c = s;
    end
    return c[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/local_mac_row.sv
// local_mac_row: one bit-cell row of the local MAC. Each lane's weight is
// extended (zero or sign per sus), gated by its activation bit, and the
// eight terms are summed through a balanced adder tree. Purely combinational.
//   wb       in  LANES*WBITS  row weights, lane i = wb[WBITS*i +: WBITS]
//   rwlb     in  LANES        activation bits, bit i enables lane i
//   sus      in  1            0 = unsigned weights, 1 = two's-complement
//   row_sum  out ROW_W        signed gated row sum
module local_mac_row
  import dcim_pkg::*;
(
  input  logic [LANES*WBITS-1:0]  wb,
  input  logic [LANES-1:0]        rwlb,
  input  logic                    sus,
  output logic signed [ROW_W-1:0] row_sum
);

  logic signed [ROW_W-1:0] term [LANES];
  logic signed [ROW_W-1:0] lvl1 [LANES/2];
  logic signed [ROW_W-1:0] lvl2 [LANES/4];

  // 16 bits suffice: 8 * 4095 = 32760 and 8 * -2048 = -16384.
  always_comb begin
    logic [WBITS-1:0] w;
    logic             ext_bit;
    w       = '0;
    ext_bit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      w       = wb[WBITS*i +: WBITS];
      ext_bit = sus & w[WBITS-1];
      term[i] = rwlb[i] ? $signed({{(ROW_W-WBITS){ext_bit}}, w}) : '0;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES/2; i++) begin
      lvl1[i] = term[2*i] + term[2*i+1];
    end
    for (int i = 0; i < LANES/4; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
    row_sum = lvl2[0] + lvl2[1];
  end

endmodule

// File: rtl/local_mac.sv
// local_mac: local multiply-accumulate slice of the DCIM macro. Two rows of
// eight gated 12-bit weights are summed, saturated to 15 bits according to
// sus, and registered. One cycle latency, a new operand set every cycle.
//   clk        in  1    clock, rising edge
//   rst        in  1    synchronous active-high reset, clears mac_out
//   wb0        in  96   row-0 weights
//   wb1        in  96   row-1 weights
//   rwlb_row0  in  8    row-0 activations
//   rwlb_row1  in  8    row-1 activations
//   sus        in  1    0 = unsigned, 1 = signed weights and result
//   mac_out    out 15   registered saturated sum
module local_mac
  import dcim_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WBITS-1:0] wb0,
  input  logic [LANES*WBITS-1:0] wb1,
  input  logic [LANES-1:0]       rwlb_row0,
  input  logic [LANES-1:0]       rwlb_row1,
  input  logic                   sus,
  output logic [OUT_W-1:0]       mac_out
);

  logic signed [ROW_W-1:0] row0_sum;
  logic signed [ROW_W-1:0] row1_sum;
  logic signed [SUM_W-1:0] raw_sum;

  local_mac_row u_row0 (
    .wb      (wb0),
    .rwlb    (rwlb_row0),
    .sus     (sus),
    .row_sum (row0_sum)
  );

  local_mac_row u_row1 (
    .wb      (wb1),
    .rwlb    (rwlb_row1),
    .sus     (sus),
    .row_sum (row1_sum)
  );

  // Row sums are signed in both modes (unsigned row max still fits 16-bit
  // signed), so a sign extension to 17 bits is always correct.
  always_comb begin
    raw_sum = $signed({row0_sum[ROW_W-1], row0_sum}) +
              $signed({row1_sum[ROW_W-1], row1_sum});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_out <= '0;
    end else begin
      mac_out <= sat_result(raw_sum, sus);
    end
  end

endmodule

// File: tb/tb_local_mac.sv
module tb_local_mac;

  logic        clk;
  logic        rst;
  logic [95:0] wb0;
  logic [95:0] wb1;
  logic [7:0]  rwlb_row0;
  logic [7:0]  rwlb_row1;
  logic        sus;
  logic [14:0] mac_out;

  logic [14:0] exp_q[$];
  int          n_checks;
  int          n_pass;
  bit          stim_done;

  local_mac dut (
    .clk       (clk),
    .rst       (rst),
    .wb0       (wb0),
    .wb1       (wb1),
    .rwlb_row0 (rwlb_row0),
    .rwlb_row1 (rwlb_row1),
    .sus       (sus),
    .mac_out   (mac_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [14:0] model(input logic [95:0] a, input logic [95:0] b,
                                        input logic [7:0] x, input logic [7:0] y,
                                        input logic s);
    int total;
    int w;
    total = 0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) begin
        w = int'(a[12*i +: 12]);
        if (s && w >= 2048) w = w - 4096;
        total += w;
      end
      if (y[i]) begin
        w = int'(b[12*i +: 12]);
        if (s && w >= 2048) w = w - 4096;
        total += w;
      end
    end
    if (!s) begin
      if (total > 32767) total = 32767;
    end else begin
      if (total > 16383) total = 16383;
      if (total < -16384) total = -16384;
    end
    return total[14:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; the rising edge that follows
  // captures them, so each pushed expectation is due one edge later.
  task automatic drive_raw(input logic r, input logic [95:0] a, input logic [95:0] b,
                           input logic [7:0] x, input logic [7:0] y, input logic s,
                           input logic [14:0] e);
    @(negedge clk);
    rst = r; wb0 = a; wb1 = b; rwlb_row0 = x; rwlb_row1 = y; sus = s;
    exp_q.push_back(e);
  endtask

  task automatic drive_model(input logic [95:0] a, input logic [95:0] b,
                             input logic [7:0] x, input logic [7:0] y, input logic s);
    drive_raw(1'b0, a, b, x, y, s, model(a, b, x, y, s));
  endtask

  task automatic drive_reset();
    drive_raw(1'b1, $urandom(), $urandom(), 8'($urandom()), 8'($urandom()), 1'($urandom()), 15'h0);
  endtask

  function automatic logic [95:0] rand_row();
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 4))
        0: r[12*i +: 12] = 12'h000;
        1: r[12*i +: 12] = 12'hFFF;
        2: r[12*i +: 12] = 12'h800;
        3: r[12*i +: 12] = 12'h7FF;
        default: r[12*i +: 12] = 12'($urandom());
      endcase
    end
    return r;
  endfunction

  function automatic logic [95:0] fill_row(input logic [11:0] v);
    logic [95:0] r;
    for (int i = 0; i < 8; i++) r[12*i +: 12] = v;
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [14:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (mac_out === e) n_pass++;
        else $display("FAIL mac_out check %0d: got %h expected %h (t=%0t)", n_checks, mac_out, e, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_pass = 0; stim_done = 0;
    rst = 1'b1; wb0 = '0; wb1 = '0; rwlb_row0 = '0; rwlb_row1 = '0; sus = 1'b0;

    drive_reset();
    drive_reset();

    // all zero
    drive_raw(0, 96'h0, 96'h0, 8'h00, 8'h00, 0, 15'h0000);
    // unsigned single lane per row
    drive_raw(0, 96'h00FFFFFFFFFFFFFFFFFFFFFF, 96'h00FFFFFFFFFFFFFFFFFFFFFF, 8'b00000001, 8'b00000001, 0, 15'h1FFE);
    // signed negative
    drive_raw(0, 96'h000000FFFFFFFFFFFFFFFFFF, 96'h0, 8'b11111100, 8'h00, 1, 15'h7FFC);
    // saturation corners
    drive_raw(0, fill_row(12'hFFF), fill_row(12'hFFF), 8'hFF, 8'hFF, 0, 15'h7FFF);
    drive_raw(0, fill_row(12'h800), fill_row(12'h800), 8'hFF, 8'hFF, 1, 15'h4000);
    drive_raw(0, fill_row(12'h7FF), fill_row(12'h7FF), 8'hFF, 8'hFF, 1, 15'h3FFF);
    // all -1 signed, exact -16 (no clamp)
    drive_raw(0, fill_row(12'hFFF), fill_row(12'hFFF), 8'hFF, 8'hFF, 1, 15'h7FF0);

    // back-to-back stream, then reset mid-stream, then resume
    drive_raw(0, 96'h123, 96'h0, 8'h01, 8'h00, 0, 15'h0123);
    drive_raw(0, 96'h0, 96'h456, 8'h00, 8'h01, 0, 15'h0456);
    drive_raw(0, 96'h789, 96'h001, 8'h01, 8'h01, 0, 15'h078A);
    drive_reset();
    drive_raw(0, 96'h100, 96'h200, 8'h01, 8'h01, 0, 15'h0300);

    // mode switch every cycle
    for (int i = 0; i < 6; i++)
      drive_raw(0, 96'hFFF, 96'h0, 8'h01, 8'h00, 1'(i % 2), (i % 2) ? 15'h7FFF : 15'h0FFF);

    // randomized operands checked against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) drive_reset();
      else drive_model(rand_row(), rand_row(), 8'($urandom()), 8'($urandom()), 1'($urandom()));
    end

    // drain: let the last expectation be compared
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain check: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/local_mac.md
# local_mac

Local multiply-accumulate slice of the DCIM macro. It gates sixteen 12-bit stored weights (two bit-cell rows of eight lanes each) with one-bit input activations and sums the gated weights. The sum is interpreted as unsigned or two's-complement under the `sus` control and saturated into a 15-bit result. It sits between the bit-cell array read path and the macro's global adder/shift-accumulate stage, with one register stage at the output.

## Interface
Parameters (fixed; overriding is not supported):
- `LANES` = 8: lanes per row.
- `WBITS` = 12: weight width per lane.
- `OUT_W` = 15: result width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wb0`  in  96  row-0 weights; lane i = `wb0[12*i+11 : 12*i]`, i = 0..7.
- `wb1`  in  96  row-1 weights, same lane packing.
- `rwlb_row0`  in  8  row-0 activation bits; bit i = 1 enables lane i.
- `rwlb_row1`  in  8  row-1 activation bits, same mapping.
- `sus`  in  1  0 = weights unsigned (0..4095); 1 = weights signed two's-complement (-2048..2047).
- `mac_out`  out  15  registered saturated sum; two's-complement when `sus` = 1.

## Operation
- Gated term per lane: the term equals the lane weight when the activation bit is 1, else 0.
- Weight extension to 17 bits:
  - `sus` = 0: zero-extend.
  - `sus` = 1: sign-extend from bit 11.
- Raw sum S = sum of all 16 gated terms, computed in 17-bit signed arithmetic with no overflow possible.
  - Unsigned range: 0..65520.
  - Signed range: -32768..32752.
- Saturation to 15 bits:
  - `sus` = 0: result = min(S, 32767).
  - `sus` = 1: result = clamp(S, -16384, 16383), two's-complement encoded.
- `sus` is per-operation and takes effect on the same cycle as the data.
- No other mode, enable or handshake exists. Every cycle computes a new result.

## Timing
- All inputs are sampled on each rising `clk` edge. `mac_out` reflects those inputs after that edge, a latency of 1 cycle, and is held until the next edge.
- Full throughput: a new operand set is accepted every cycle.
- Reset: while `rst` = 1 at a rising edge, `mac_out` becomes 15'h0000 and inputs are ignored.
  - The first valid result appears one cycle after the first edge with `rst` = 0.
  - Reset asserted mid-stream discards the in-flight result.
- No combinational path from inputs to `mac_out`.

## Structure
- Shared package `dcim_pkg`:
  - constants `LANES`, `WBITS`, `OUT_W`, `SUM_W` = 17;
  - saturation limits `U_MAX` = 32767, `S_MAX` = 16383, `S_MIN` = -16384.
- One natural sub-module, `local_mac_row`:
  - inputs: one row's 96-bit weights, 8 activation bits and `sus`;
  - output: 16-bit signed row sum from an 8-lane gated adder tree.
- The top level instantiates two rows, adds them, saturates and registers the result.

## Test plan
- All inputs 0 (`sus` = 0, weights 0, activations 0) → `mac_out` = 15'h0000 one cycle later.
- Unsigned single lane per row:
  - stimulus: `sus` = 0, both weight buses = 96'h00FFFFFFFFFFFFFFFFFFFFFF, both activation buses = 8'b00000001;
  - response: 4095 + 4095 = 15'h1FFE.
- Signed negative:
  - stimulus: `sus` = 1, `wb0` = 96'h000000FFFFFFFFFFFFFFFFFF (lanes 0-5 = -1, lanes 6-7 = 0), `rwlb_row0` = 8'b11111100, `wb1` = 0, `rwlb_row1` = 0;
  - response: -4 = 15'h7FFC.
- Saturation:
  - all lanes 12'hFFF, all activations 1, `sus` = 0 → 15'h7FFF;
  - all lanes 12'h800, `sus` = 1 → 15'h4000;
  - all lanes 12'h7FF, `sus` = 1 → 15'h3FFF.
- Reset and latency:
  - stream three operand sets back-to-back and check each result appears exactly one cycle after its inputs;
  - assert `rst` for one cycle mid-stream → `mac_out` = 0 that cycle, normal results resume after deassertion.
- Mode switch: identical operands with `sus` toggling every cycle (weight 12'hFFF, one lane active) → results alternate 15'h0FFF / 15'h7FFF.
